// File: rtl/sti4_sbox_sched_if.sv
// Bus bundle for the serialized TI S-box sequencer:
// state in/out handshakes, core link and mask nibble.
interface sti4_sbox_sched_if #(
  parameter int NIBBLES = 16,
  parameter int SHARES  = 3
);
  localparam int W = 4 * NIBBLES * SHARES;

  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [W-1:0]          out_data;
  logic [4*SHARES-1:0]   core_x;
  logic                  core_en1;
  logic [4*SHARES-1:0]   core_y;
  logic [3:0]            rnd_in;
  logic                  rnd_req;

  modport slave (
    input  in_valid, in_data, out_ready,
    input  core_y, rnd_in,
    output in_ready, out_valid, out_data,
    output core_x, core_en1, rnd_req
  );

  modport master (
    output in_valid, in_data, out_ready,
    output core_y, rnd_in,
    input  in_ready, out_valid, out_data,
    input  core_x, core_en1, rnd_req
  );
endinterface

// File: rtl/sti4_sbox_sched.sv
// Serial sequencer feeding one shared nibble per step to a 2-stage TI S-box core.
// Optional remasking of shares 0/1 with rnd_in when STI4_REMASK_EN is defined.
module sti4_sbox_sched #(
  parameter int NIBBLES = 16,
  parameter int SHARES  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                abort,
  sti4_sbox_sched_if.slave    bus,
  output logic                busy
);
  localparam int NW = 4 * NIBBLES;
  localparam int W  = NW * SHARES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    S1,
    S2,
    OUT
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IW-1:0]       r_idx;
  logic [IW-1:0]       w_idx_nxt;
  logic [W-1:0]        r_buf;
  logic [W-1:0]        w_buf_nxt;
  logic [4*SHARES-1:0] w_core_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  // abort wins over every handshake in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_buf_nxt   = r_buf;
    if (abort) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            w_buf_nxt   = bus.in_data;
            w_idx_nxt   = '0;
            w_state_nxt = S1;
          end
        end
        S1: w_state_nxt = S2;
        S2: begin
          for (int s = 0; s < SHARES; s++) begin
            w_buf_nxt[s*NW + 4*r_idx +: 4] =
              bus.core_y[4*s +: 4];
          end
          if (r_idx == LAST) begin
            w_state_nxt = OUT;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = S1;
          end
        end
        OUT: begin
          if (bus.out_ready) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // core input is forced to zero outside S1
  always_comb begin
    w_core_x = '0;
    if (r_state == S1) begin
      for (int s = 0; s < SHARES; s++) begin
        w_core_x[4*s +: 4] = r_buf[s*NW + 4*r_idx +: 4];
      end
`ifdef STI4_REMASK_EN
      w_core_x[3:0] = w_core_x[3:0] ^ bus.rnd_in;
      w_core_x[7:4] = w_core_x[7:4] ^ bus.rnd_in;
`endif
    end
  end

`ifdef STI4_REMASK_EN
  assign bus.rnd_req = (r_state == S1);
`else
  logic w_unused_rnd;
  assign w_unused_rnd = ^bus.rnd_in;
  assign bus.rnd_req  = 1'b0;
`endif

  assign bus.core_x    = w_core_x;
  assign bus.core_en1  = (r_state == S1);
  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == OUT);
  assign bus.out_data  = r_buf;
  assign busy          = (r_state != IDLE);
endmodule
